// File: rtl/hash_table_lp_pkg.sv
// rtl/hash_table_lp_pkg.sv - shared operation codes, slot states and FSM states
package hash_table_lp_pkg;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'b00,
      OP_INSERT = 2'b01,
      OP_DELETE = 2'b10,
      OP_CLEAR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'b00,
      SLOT_VALID = 2'b01,
      SLOT_TOMB  = 2'b10
   } slot_state_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PROBE     = 3'd1,
      ST_SSD_ISSUE = 3'd2,
      ST_SSD_WAIT  = 3'd3,
      ST_CLEAR     = 3'd4,
      ST_RESP      = 3'd5
   } fsm_state_e;

endpackage

// File: rtl/hash_table_lp_if.sv
// rtl/hash_table_lp_if.sv - request/response and SSD command bundle
interface hash_table_lp_if #(
   parameter int KEY_W   = 32,
   parameter int VALUE_W = 32,
   parameter int DATA_W  = 512,
   parameter int CNT_W   = 5
);
   logic               req_valid;
   logic               req_ready;
   logic [1:0]         operation;
   logic [KEY_W-1:0]   key;
   logic [DATA_W-1:0]  photo_data;
   logic               resp_valid;
   logic               hit;
   logic               success;
   logic [VALUE_W-1:0] value_out;
   logic [CNT_W-1:0]   count;
   logic               ssd_write;
   logic               ssd_delete;
   logic [DATA_W-1:0]  ssd_data_out;
   logic [VALUE_W-1:0] ssd_addr_out;
   logic [VALUE_W-1:0] ssd_addr_in;
   logic               ssd_ready;
   logic               ssd_done;

   modport master (
      output req_valid, operation, key, photo_data, ssd_addr_in, ssd_ready, ssd_done,
      input  req_ready, resp_valid, hit, success, value_out, count,
             ssd_write, ssd_delete, ssd_data_out, ssd_addr_out
   );

   modport slave (
      input  req_valid, operation, key, photo_data, ssd_addr_in, ssd_ready, ssd_done,
      output req_ready, resp_valid, hit, success, value_out, count,
             ssd_write, ssd_delete, ssd_data_out, ssd_addr_out
   );
endinterface

// File: rtl/hash_slot_ram.sv
// rtl/hash_slot_ram.sv - slot array with async read, sync write, resettable states
module hash_slot_ram
   import hash_table_lp_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int KEY_W   = 32,
   parameter int VALUE_W = 32,
   localparam int L      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [L-1:0]       i_raddr,
   output slot_state_e        o_rstate,
   output logic [KEY_W-1:0]   o_rkey,
   output logic [VALUE_W-1:0] o_rval,
   input  logic               i_we,
   input  logic [L-1:0]       i_waddr,
   input  slot_state_e        i_wstate,
   input  logic [KEY_W-1:0]   i_wkey,
   input  logic [VALUE_W-1:0] i_wval
);
   slot_state_e        r_state [DEPTH];
   logic [KEY_W-1:0]   r_key   [DEPTH];
   logic [VALUE_W-1:0] r_val   [DEPTH];

   // slot states clear to EMPTY on reset so the table is empty the moment reset drops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_state[i] <= SLOT_EMPTY;
      end else if (i_we) begin
         r_state[i_waddr] <= i_wstate;
      end
   end

   // key/address payload is only meaningful behind a non-EMPTY state, so it is not reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_key[i_waddr] <= i_wkey;
         r_val[i_waddr] <= i_wval;
      end
   end

   assign o_rstate = r_state[i_raddr];
   assign o_rkey   = r_key[i_raddr];
   assign o_rval   = r_val[i_raddr];
endmodule

// File: rtl/hash_table_lp.sv
// rtl/hash_table_lp.sv - linear-probing key->SSD address table with SSD command sequencing
module hash_table_lp #(
   parameter int KEY_W     = 32,
   parameter int DEPTH     = 16,
   parameter int VALUE_W   = 32,
   parameter int DATA_W    = 512,
   parameter int MAX_PROBE = DEPTH
) (
   input  logic          clk,
   input  logic          reset_n,
   hash_table_lp_if.slave bus
);
   import hash_table_lp_pkg::*;

   localparam int L = $clog2(DEPTH);
   localparam logic [L:0]   PROBE_LAST = (L+1)'(MAX_PROBE - 1);
   localparam logic [L-1:0] IDX_LAST   = L'(DEPTH - 1);

   fsm_state_e         r_fsm;
   op_e                r_op;
   logic [KEY_W-1:0]   r_key;
   logic [DATA_W-1:0]  r_data;
   logic [L-1:0]       r_idx;
   logic [L:0]         r_probes;
   logic               r_have_free;
   logic [L-1:0]       r_free_idx;
   logic [L-1:0]       r_target;
   logic [VALUE_W-1:0] r_del_addr;
   logic               r_p_hit, r_p_success;
   logic [VALUE_W-1:0] r_p_value;
   logic               r_req_ready, r_resp_valid, r_hit, r_success;
   logic [VALUE_W-1:0] r_value;
   logic [L:0]         r_count;
   logic               r_ssd_write, r_ssd_delete;
   logic [DATA_W-1:0]  r_ssd_data;
   logic [VALUE_W-1:0] r_ssd_addr;

   slot_state_e        w_rd_state;
   logic [KEY_W-1:0]   w_rd_key;
   logic [VALUE_W-1:0] w_rd_val;
   logic               w_we;
   logic [L-1:0]       w_waddr;
   slot_state_e        w_wstate;
   logic [VALUE_W-1:0] w_wval;
   logic [L-1:0]       w_hash;
   logic               w_key_match, w_rd_empty, w_last, w_free_any;
   logic [L-1:0]       w_free_sel;
   logic               w_advance, w_go_ssd, w_record_free, w_res_hit, w_res_success;
   logic [VALUE_W-1:0] w_res_value;

   hash_slot_ram #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VALUE_W(VALUE_W)) u_ram (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raddr  (r_idx),
      .o_rstate (w_rd_state),
      .o_rkey   (w_rd_key),
      .o_rval   (w_rd_val),
      .i_we     (w_we),
      .i_waddr  (w_waddr),
      .i_wstate (w_wstate),
      .i_wkey   (r_key),
      .i_wval   (w_wval)
   );

   assign w_hash      = bus.key[L-1:0] ^ bus.key[2*L-1:L];
   assign w_key_match = (w_rd_state == SLOT_VALID) && (w_rd_key == r_key);
   assign w_rd_empty  = (w_rd_state == SLOT_EMPTY);
   assign w_last      = (r_probes == PROBE_LAST);
   assign w_free_any  = r_have_free || (w_rd_state != SLOT_VALID);
   assign w_free_sel  = r_have_free ? r_free_idx : r_idx;

   // per-probe decision: advance to next slot, go issue an SSD command, or finish with a result
   always_comb begin
      w_advance     = 1'b0;
      w_go_ssd      = 1'b0;
      w_record_free = 1'b0;
      w_res_hit     = 1'b0;
      w_res_success = 1'b0;
      w_res_value   = '0;
      case (r_op)
         OP_LOOKUP: begin
            if (w_key_match) begin
               w_res_hit     = 1'b1;
               w_res_success = 1'b1;
               w_res_value   = w_rd_val;
            end else if (!w_rd_empty && !w_last) begin
               w_advance = 1'b1;
            end
         end
         OP_INSERT: begin
            if (w_key_match) begin
               w_res_hit = 1'b1;
            end else if (w_rd_empty || w_last) begin
               w_go_ssd = w_free_any;
            end else begin
               w_advance     = 1'b1;
               w_record_free = (w_rd_state == SLOT_TOMB) && !r_have_free;
            end
         end
         OP_DELETE: begin
            if (w_key_match) begin
               w_go_ssd = 1'b1;
            end else if (!w_rd_empty && !w_last) begin
               w_advance = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // slot writes: clear sweep, or commit on SSD completion
   always_comb begin
      w_we     = 1'b0;
      w_waddr  = r_target;
      w_wstate = SLOT_EMPTY;
      w_wval   = '0;
      if (r_fsm == ST_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_idx;
      end else if (r_fsm == ST_SSD_WAIT && bus.ssd_done) begin
         w_we = 1'b1;
         if (r_op == OP_INSERT) begin
            w_wstate = SLOT_VALID;
            w_wval   = bus.ssd_addr_in;
         end else begin
            w_wstate = SLOT_TOMB;
            w_wval   = r_del_addr;
         end
      end
   end

   // main FSM with registered outputs; reset abandons any in-flight SSD operation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fsm        <= ST_IDLE;
         r_op         <= OP_LOOKUP;
         r_key        <= '0;
         r_data       <= '0;
         r_idx        <= '0;
         r_probes     <= '0;
         r_have_free  <= 1'b0;
         r_free_idx   <= '0;
         r_target     <= '0;
         r_del_addr   <= '0;
         r_p_hit      <= 1'b0;
         r_p_success  <= 1'b0;
         r_p_value    <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_hit        <= 1'b0;
         r_success    <= 1'b0;
         r_value      <= '0;
         r_count      <= '0;
         r_ssd_write  <= 1'b0;
         r_ssd_delete <= 1'b0;
         r_ssd_data   <= '0;
         r_ssd_addr   <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_ssd_write  <= 1'b0;
         r_ssd_delete <= 1'b0;
         case (r_fsm)
            ST_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_op        <= op_e'(bus.operation);
                  r_key       <= bus.key;
                  r_data      <= bus.photo_data;
                  r_probes    <= '0;
                  r_have_free <= 1'b0;
                  if (op_e'(bus.operation) == OP_CLEAR) begin
                     r_idx <= '0;
                     r_fsm <= ST_CLEAR;
                  end else begin
                     r_idx <= w_hash;
                     r_fsm <= ST_PROBE;
                  end
               end
            end
            ST_PROBE: begin
               if (w_record_free) begin
                  r_have_free <= 1'b1;
                  r_free_idx  <= r_idx;
               end
               if (w_advance) begin
                  r_idx    <= r_idx + 1'b1;
                  r_probes <= r_probes + 1'b1;
               end else if (w_go_ssd) begin
                  r_target   <= (r_op == OP_INSERT) ? w_free_sel : r_idx;
                  r_del_addr <= w_rd_val;
                  r_fsm      <= ST_SSD_ISSUE;
               end else begin
                  r_p_hit     <= w_res_hit;
                  r_p_success <= w_res_success;
                  r_p_value   <= w_res_value;
                  r_fsm       <= ST_RESP;
               end
            end
            ST_SSD_ISSUE: begin
               if (bus.ssd_ready) begin
                  if (r_op == OP_INSERT) begin
                     r_ssd_write <= 1'b1;
                     r_ssd_data  <= r_data;
                  end else begin
                     r_ssd_delete <= 1'b1;
                     r_ssd_addr   <= r_del_addr;
                  end
                  r_fsm <= ST_SSD_WAIT;
               end
            end
            ST_SSD_WAIT: begin
               if (bus.ssd_done) begin
                  r_p_success <= 1'b1;
                  if (r_op == OP_INSERT) begin
                     r_count   <= r_count + 1'b1;
                     r_p_hit   <= 1'b0;
                     r_p_value <= bus.ssd_addr_in;
                  end else begin
                     r_count   <= r_count - 1'b1;
                     r_p_hit   <= 1'b1;
                     r_p_value <= r_del_addr;
                  end
                  r_fsm <= ST_RESP;
               end
            end
            ST_CLEAR: begin
               if (r_idx == IDX_LAST) begin
                  r_count     <= '0;
                  r_p_hit     <= 1'b0;
                  r_p_success <= 1'b1;
                  r_p_value   <= '0;
                  r_fsm       <= ST_RESP;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_RESP: begin
               r_resp_valid <= 1'b1;
               r_hit        <= r_p_hit;
               r_success    <= r_p_success;
               r_value      <= r_p_value;
               r_req_ready  <= 1'b1;
               r_fsm        <= ST_IDLE;
            end
            default: begin
               r_req_ready <= 1'b1;
               r_fsm       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = r_req_ready;
   assign bus.resp_valid   = r_resp_valid;
   assign bus.hit          = r_hit;
   assign bus.success      = r_success;
   assign bus.value_out    = r_value;
   assign bus.count        = r_count;
   assign bus.ssd_write    = r_ssd_write;
   assign bus.ssd_delete   = r_ssd_delete;
   assign bus.ssd_data_out = r_ssd_data;
   assign bus.ssd_addr_out = r_ssd_addr;
endmodule

// File: tb/tb_hash_table_lp.sv
// tb/tb_hash_table_lp.sv - directed self-checking bench for hash_table_lp
module tb_hash_table_lp;
   import hash_table_lp_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   hash_table_lp_if #(.KEY_W(32), .VALUE_W(32), .DATA_W(512), .CNT_W(5)) bus ();

   hash_table_lp #(.KEY_W(32), .DEPTH(16), .VALUE_W(32), .DATA_W(512), .MAX_PROBE(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_wr    = 0;
   int n_del   = 0;
   int n_both  = 0;
   logic        got_hit, got_succ;
   logic [31:0] got_val;
   int          got_lat;
   logic [511:0] last_wdata;
   logic [31:0]  last_del_addr;
   logic [31:0]  ssd_ret;

   task automatic do_op(input logic [1:0] op, input logic [31:0] k, input logic [511:0] d, input int stall);
      bit done;
      int w;
      w = 0;
      while (bus.req_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
      bus.operation  = op;
      bus.key        = k;
      bus.photo_data = d;
      bus.req_valid  = 1'b1;
      bus.ssd_ready  = (stall == 0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      done    = 0;
      got_lat = -1;
      for (int c = 1; c <= 200 && !done; c++) begin
         @(posedge clk); #1;
         bus.ssd_done = 1'b0;
         if (c >= stall) bus.ssd_ready = 1'b1;
         if (bus.ssd_write && bus.ssd_delete) n_both++;
         if (bus.ssd_write) begin
            n_wr++; last_wdata = bus.ssd_data_out;
            bus.ssd_done = 1'b1; bus.ssd_addr_in = ssd_ret;
         end
         if (bus.ssd_delete) begin
            n_del++; last_del_addr = bus.ssd_addr_out;
            bus.ssd_done = 1'b1;
         end
         if (bus.resp_valid) begin
            done = 1; got_lat = c;
            got_hit = bus.hit; got_succ = bus.success; got_val = bus.value_out;
         end
      end
      bus.ssd_done  = 1'b0;
      bus.ssd_ready = 1'b1;
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL op_timeout op=%0d key=%0h got no resp_valid, required one", op, k);
      end
   endtask

   task automatic test_reset();
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%0b exp=1", bus.req_ready); end
      n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%0b exp=0", bus.resp_valid); end
      n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
      n_tests++; if ({bus.ssd_write, bus.ssd_delete, bus.hit, bus.success} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got=%b exp=0000", {bus.ssd_write, bus.ssd_delete, bus.hit, bus.success}); end
      n_tests++; if (bus.value_out !== 32'd0) begin n_fail++; $display("FAIL rst_value got=%0h exp=0", bus.value_out); end
   endtask

   task automatic test_insert_lookup();
      int wr0;
      wr0 = n_wr; ssd_ret = 32'h0;
      do_op(OP_INSERT, 32'h05, 512'h50, 0);
      n_tests++; if (got_succ !== 1'b1 || got_hit !== 1'b0) begin n_fail++; $display("FAIL ins05_status got=%b%b exp=10", got_succ, got_hit); end
      n_tests++; if (n_wr - wr0 != 1) begin n_fail++; $display("FAIL ins05_writes got=%0d exp=1", n_wr - wr0); end
      n_tests++; if (last_wdata !== 512'h50) begin n_fail++; $display("FAIL ins05_wdata got=%0h exp=50", last_wdata); end
      n_tests++; if (got_lat != 4) begin n_fail++; $display("FAIL ins05_lat got=%0d exp=4", got_lat); end
      n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL ins05_count got=%0d exp=1", bus.count); end
      do_op(OP_LOOKUP, 32'h05, '0, 0);
      n_tests++; if (got_hit !== 1'b1 || got_succ !== 1'b1 || got_val !== 32'h0) begin n_fail++; $display("FAIL lk05 got hit=%b succ=%b val=%0h exp 1 1 0", got_hit, got_succ, got_val); end
      n_tests++; if (got_lat != 2) begin n_fail++; $display("FAIL lk05_lat got=%0d exp=2", got_lat); end
   endtask

   task automatic test_collision();
      ssd_ret = 32'h100; do_op(OP_INSERT, 32'h03, 512'h33, 0);
      ssd_ret = 32'h200; do_op(OP_INSERT, 32'h30, 512'h3030, 0);
      n_tests++; if (got_succ !== 1'b1 || got_val !== 32'h200) begin n_fail++; $display("FAIL ins30 got succ=%b val=%0h exp 1 200", got_succ, got_val); end
      do_op(OP_LOOKUP, 32'h30, '0, 0);
      n_tests++; if (got_hit !== 1'b1 || got_val !== 32'h200) begin n_fail++; $display("FAIL lk30 got hit=%b val=%0h exp 1 200", got_hit, got_val); end
      n_tests++; if (got_lat != 3) begin n_fail++; $display("FAIL lk30_lat got=%0d exp=3", got_lat); end
      n_tests++; if (bus.count !== 5'd3) begin n_fail++; $display("FAIL coll_count got=%0d exp=3", bus.count); end
      repeat (2) @(posedge clk); #1;
      n_tests++; if (bus.resp_valid !== 1'b0 || bus.hit !== 1'b1 || bus.value_out !== 32'h200) begin n_fail++; $display("FAIL hold got rv=%b hit=%b val=%0h exp 0 1 200", bus.resp_valid, bus.hit, bus.value_out); end
   endtask

   task automatic test_delete();
      int del0, wr0;
      del0 = n_del;
      do_op(OP_DELETE, 32'h03, '0, 0);
      n_tests++; if (got_succ !== 1'b1 || got_hit !== 1'b1) begin n_fail++; $display("FAIL del03 got succ=%b hit=%b exp 1 1", got_succ, got_hit); end
      n_tests++; if (n_del - del0 != 1 || last_del_addr !== 32'h100) begin n_fail++; $display("FAIL del03_cmd got n=%0d addr=%0h exp 1 100", n_del - del0, last_del_addr); end
      n_tests++; if (bus.count !== 5'd2) begin n_fail++; $display("FAIL del03_count got=%0d exp=2", bus.count); end
      do_op(OP_LOOKUP, 32'h30, '0, 0);
      n_tests++; if (got_hit !== 1'b1 || got_val !== 32'h200 || got_lat != 3) begin n_fail++; $display("FAIL lk30_tomb got hit=%b val=%0h lat=%0d exp 1 200 3", got_hit, got_val, got_lat); end
      ssd_ret = 32'h300; do_op(OP_INSERT, 32'h12, 512'h12, 0);
      do_op(OP_LOOKUP, 32'h12, '0, 0);
      n_tests++; if (got_hit !== 1'b1 || got_val !== 32'h300 || got_lat != 2) begin n_fail++; $display("FAIL lk12_reuse got hit=%b val=%0h lat=%0d exp 1 300 2", got_hit, got_val, got_lat); end
      do_op(OP_LOOKUP, 32'h03, '0, 0);
      n_tests++; if (got_hit !== 1'b0 || got_succ !== 1'b0 || got_val !== 32'h0 || got_lat != 5) begin n_fail++; $display("FAIL lk03_miss got hit=%b succ=%b val=%0h lat=%0d exp 0 0 0 5", got_hit, got_succ, got_val, got_lat); end
      del0 = n_del; wr0 = n_wr;
      do_op(OP_DELETE, 32'h77, '0, 0);
      n_tests++; if (got_succ !== 1'b0 || got_hit !== 1'b0 || n_del != del0 || n_wr != wr0) begin n_fail++; $display("FAIL del77_miss got succ=%b hit=%b cmds=%0d exp 0 0 0", got_succ, got_hit, (n_del - del0) + (n_wr - wr0)); end
   endtask

   task automatic test_clear();
      int wr0, del0;
      ssd_ret = 32'h400; do_op(OP_INSERT, 32'h40, 512'h40, 0);
      ssd_ret = 32'h500; do_op(OP_INSERT, 32'h0A, 512'h0A, 0);
      n_tests++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL pre_clear_count got=%0d exp=5", bus.count); end
      wr0 = n_wr; del0 = n_del;
      do_op(OP_CLEAR, 32'h0, '0, 0);
      n_tests++; if (got_lat != 17 || got_succ !== 1'b1) begin n_fail++; $display("FAIL clear got lat=%0d succ=%b exp 17 1", got_lat, got_succ); end
      n_tests++; if (bus.count !== 5'd0 || n_wr != wr0 || n_del != del0) begin n_fail++; $display("FAIL clear_state got count=%0d cmds=%0d exp 0 0", bus.count, (n_wr - wr0) + (n_del - del0)); end
      do_op(OP_LOOKUP, 32'h05, '0, 0);
      n_tests++; if (got_hit !== 1'b0 || got_lat != 2) begin n_fail++; $display("FAIL clear_lk05 got hit=%b lat=%0d exp 0 2", got_hit, got_lat); end
   endtask

   task automatic test_full();
      int wr0, n_ok;
      n_ok = 0; wr0 = n_wr;
      for (int k = 0; k < 16; k++) begin
         ssd_ret = 32'(k) << 4;
         do_op(OP_INSERT, 32'(k), 512'(k), 0);
         if (got_succ === 1'b1) n_ok++;
      end
      n_tests++; if (n_ok != 16 || n_wr - wr0 != 16) begin n_fail++; $display("FAIL fill got ok=%0d writes=%0d exp 16 16", n_ok, n_wr - wr0); end
      n_tests++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_count got=%0d exp=16", bus.count); end
      wr0 = n_wr;
      do_op(OP_INSERT, 32'h10, 512'h10, 0);
      n_tests++; if (got_succ !== 1'b0 || got_hit !== 1'b0 || n_wr != wr0 || got_lat != 17) begin n_fail++; $display("FAIL ins_overflow got succ=%b hit=%b wr=%0d lat=%0d exp 0 0 0 17", got_succ, got_hit, n_wr - wr0, got_lat); end
      do_op(OP_INSERT, 32'h07, 512'h77, 0);
      n_tests++; if (got_succ !== 1'b0 || got_hit !== 1'b1 || n_wr != wr0) begin n_fail++; $display("FAIL ins_dup got succ=%b hit=%b wr=%0d exp 0 1 0", got_succ, got_hit, n_wr - wr0); end
      do_op(OP_LOOKUP, 32'h10, '0, 0);
      n_tests++; if (got_hit !== 1'b0 || got_lat != 17) begin n_fail++; $display("FAIL lk_limit got hit=%b lat=%0d exp 0 17", got_hit, got_lat); end
      do_op(OP_LOOKUP, 32'h0F, '0, 0);
      n_tests++; if (got_hit !== 1'b1 || got_val !== 32'hF0) begin n_fail++; $display("FAIL lk0F got hit=%b val=%0h exp 1 f0", got_hit, got_val); end
   endtask

   task automatic test_reset_in_ssd_wait();
      bit seen;
      do_op(OP_DELETE, 32'h0F, '0, 0);
      n_tests++; if (got_succ !== 1'b1 || last_del_addr !== 32'hF0) begin n_fail++; $display("FAIL del0F got succ=%b addr=%0h exp 1 f0", got_succ, last_del_addr); end
      bus.operation = OP_INSERT; bus.key = 32'h1F; bus.photo_data = 512'hABCD; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         if (bus.ssd_write) begin seen = 1; n_wr++; end
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL wait_write got none exp one ssd_write"); end
      @(posedge clk); #1;
      reset_n = 1'b0; #1;
      n_tests++; if (bus.count !== 5'd0 || bus.resp_valid !== 1'b0 || bus.ssd_write !== 1'b0) begin n_fail++; $display("FAIL rst_wait got count=%0d rv=%b wr=%b exp 0 0 0", bus.count, bus.resp_valid, bus.ssd_write); end
      n_tests++; if (bus.ssd_data_out !== 512'h0 || bus.ssd_addr_out !== 32'h0 || bus.value_out !== 32'h0) begin n_fail++; $display("FAIL rst_wait_data got data=%0h addr=%0h val=%0h exp 0 0 0", bus.ssd_data_out, bus.ssd_addr_out, bus.value_out); end
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready got=%b exp=1", bus.req_ready); end
      bus.ssd_done = 1'b1; @(posedge clk); #1; bus.ssd_done = 1'b0;
      n_tests++; if (bus.count !== 5'd0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_done got count=%0d rv=%b exp 0 0", bus.count, bus.resp_valid); end
      do_op(OP_LOOKUP, 32'h03, '0, 0);
      n_tests++; if (got_hit !== 1'b0 || got_succ !== 1'b0) begin n_fail++; $display("FAIL rst_lk03 got hit=%b succ=%b exp 0 0", got_hit, got_succ); end
   endtask

   task automatic test_ssd_stall();
      int wr0;
      wr0 = n_wr; ssd_ret = 32'h777;
      do_op(OP_INSERT, 32'h21, 512'h21, 3);
      n_tests++; if (got_lat != 6 || got_succ !== 1'b1 || got_val !== 32'h777) begin n_fail++; $display("FAIL stall_ins got lat=%0d succ=%b val=%0h exp 6 1 777", got_lat, got_succ, got_val); end
      n_tests++; if (n_wr - wr0 != 1 || bus.count !== 5'd1) begin n_fail++; $display("FAIL stall_state got wr=%0d count=%0d exp 1 1", n_wr - wr0, bus.count); end
      n_tests++; if (n_both != 0) begin n_fail++; $display("FAIL both_cmds got=%0d exp=0", n_both); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no completion exp finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      bus.req_valid = 1'b0; bus.operation = 2'b00; bus.key = '0; bus.photo_data = '0;
      bus.ssd_addr_in = '0; bus.ssd_ready = 1'b1; bus.ssd_done = 1'b0;
      ssd_ret = '0; last_wdata = '0; last_del_addr = '0;
      got_hit = 1'b0; got_succ = 1'b0; got_val = '0; got_lat = 0;
      repeat (3) @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_insert_lookup();
      test_collision();
      test_delete();
      test_clear();
      test_full();
      test_reset_in_ssd_wait();
      test_ssd_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
